mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
- Sequencer for the MAC array (rows of mac_row tiles).
- On a start pulse it runs three phases in order:
  - kernel-load: streams col weight words from SRAM into the array with inst_w=01.
  - execute: streams num_vec activation vectors with inst_w=10.
  - drain: waits until num_vec results emerge on the last-column valid.
- Drives the activation/weight SRAM port, generates output-FIFO write strobes, and reports done or a drain timeout.

Parameters:
- col, 8, array columns; number of kernel-load cycles.
- len_bw, 8, width of num_vec and of the result counter.
- addr_bw, 11, SRAM address width.
- drain_max, 64, maximum DRAIN cycles before timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only in IDLE.
- num_vec  in  len_bw  activation vectors to stream; latched at start.
- w_base  in  addr_bw  first weight address; latched at start.
- x_base  in  addr_bw  first activation address; latched at start.
- inst_w  out  2  array instruction: [1] execute, [0] kernel load.
- xmem_cen  out  1  SRAM chip enable, active-low.
- xmem_a  out  addr_bw  SRAM read address.
- array_valid  in  col  valid vector from the array's last row.
- ofifo_wr  out  1  output-FIFO write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  drain timeout; held until the next accepted start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE, inst_w=00, xmem_cen=1, xmem_a=0, busy=0, done=0, err=0, ofifo_wr=0, all counters 0.
- Reset asserted mid-operation: FSM returns to IDLE on the next edge; no done pulse; pending results are discarded.
- ofifo_wr is forced to 0 while reset is high.
- States: IDLE, LOAD, EXEC, DRAIN, DONE.
- IDLE:
  - start=1 latches num_vec, w_base and x_base, clears err and both counters, and moves to LOAD.
  - start outside IDLE is ignored.
- LOAD (exactly col cycles, k=0..col-1):
  - xmem_cen=0, xmem_a=w_base+k.
  - After the last cycle: go to EXEC if num_vec>0, else DRAIN.
- EXEC (exactly num_vec cycles, j=0..num_vec-1):
  - xmem_cen=0, xmem_a=x_base+j. Then go to DRAIN.
- Address arithmetic wraps modulo 2^addr_bw.
- xmem_cen=1 in IDLE, DRAIN and DONE. xmem_a holds its last value when not reading.
- SRAM has 1-cycle read latency, so inst_w is registered one cycle behind the phase:
  - inst_w=01 on the cycle after each LOAD cycle.
  - inst_w=10 on the cycle after each EXEC cycle.
  - inst_w=00 otherwise.
  - Result: inst_w=01 holds for exactly col cycles, and inst_w=10 for exactly num_vec cycles, contiguous with the load window.
- Result counting:
  - Active in EXEC and DRAIN only.
  - ofifo_wr = array_valid[col-1] AND (result count < num_vec). Combinational, same cycle as valid.
  - Each ofifo_wr increments the result count. Extra valids beyond num_vec are ignored; the counter saturates.
  - array_valid in IDLE, LOAD or DONE is ignored.
- DRAIN:
  - Increments a drain timer each cycle.
  - Goes to DONE when result count == num_vec (checked after the current cycle's increment).
  - Also goes to DONE with err set when the timer reaches drain_max.
  - num_vec=0: DRAIN exits after one cycle, without timeout.
- DONE: done=1 for one cycle, busy stays 1, then IDLE. A start asserted during DONE is ignored.
- Latency from start to done, with results arriving promptly: 1 + col + num_vec + drain cycles + 1.

Test Plan:
- Basic run: reset, then start with num_vec=4, w_base=0x010, x_base=0x100.
  - xmem_a = 0x010..0x017 over 8 cycles, then 0x100..0x103.
  - inst_w=01 for 8 cycles, then 10 for 4 cycles, each one cycle after the corresponding address.
  - Model returns 4 array_valid[7] pulses; 4 ofifo_wr pulses; done pulses once; err=0.
- Zero vectors: num_vec=0.
  - 8 load cycles, no inst_w=10, no SRAM reads after load, done one cycle after DRAIN entry.
- Timeout: num_vec=3, model returns only 2 valids.
  - After 64 DRAIN cycles: done=1 and err=1.
  - err clears on the next start.
- Excess and early valid:
  - 5 valids for num_vec=3 gives exactly 3 ofifo_wr.
  - A valid during LOAD gives no ofifo_wr.
- Start while busy and reset mid-EXEC:
  - start pulses in EXEC are ignored; the run completes unchanged.
  - reset asserted in EXEC cycle 2: next cycle inst_w=00, xmem_cen=1, busy=0, no done.
- Address wrap: w_base=0x7FC, col=8.
  - Addresses 0x7FC..0x7FF, then 0x000..0x003.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// Sequencer for the MAC array: streams weights, then activations, from SRAM,
// then waits for the array's results and strobes them into the output FIFO.
module mac_array_ctrl #(
  parameter int col       = 8,
  parameter int len_bw    = 8,
  parameter int addr_bw   = 11,
  parameter int drain_max = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [len_bw-1:0]  num_vec,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  output logic [1:0]         inst_w,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_a,
  input  logic [col-1:0]     array_valid,
  output logic               ofifo_wr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int idx_bw   = (len_bw > $clog2(col)) ? len_bw : $clog2(col);
  localparam int drain_bw = $clog2(drain_max + 1);

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_load  = 3'd1;
  localparam logic [2:0] st_exec  = 3'd2;
  localparam logic [2:0] st_drain = 3'd3;
  localparam logic [2:0] st_done  = 3'd4;

  localparam logic [idx_bw-1:0]   last_load  = idx_bw'(col - 1);
  localparam logic [drain_bw-1:0] last_drain = drain_bw'(drain_max - 1);

  logic [2:0]          state;
  logic [len_bw-1:0]   nv;
  logic [len_bw-1:0]   res_cnt;
  logic [len_bw-1:0]   res_next;
  logic [addr_bw-1:0]  wb;
  logic [addr_bw-1:0]  xb;
  logic [addr_bw-1:0]  last_a;
  logic [addr_bw-1:0]  rd_addr;
  logic [idx_bw-1:0]   idx;
  logic [drain_bw-1:0] drain_cnt;
  logic                reading;
  logic                counting;
  logic                unused_valid;

  // Only the last column's valid marks a finished result vector.
  assign unused_valid = ^array_valid[col-2:0];

  always_comb begin
    reading  = (state == st_load) || (state == st_exec);
    counting = (state == st_exec) || (state == st_drain);
    rd_addr  = (state == st_load) ? (wb + addr_bw'(idx)) : (xb + addr_bw'(idx));
    ofifo_wr = !reset && counting && array_valid[col-1] && (res_cnt < nv);
    res_next = res_cnt + len_bw'(ofifo_wr);
  end

  assign xmem_cen = !reading;
  assign xmem_a   = reading ? rd_addr : last_a;
  assign busy     = (state != st_idle);
  assign done     = (state == st_done);

  // inst_w trails the read phase by one cycle to match the SRAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= st_idle;
      nv        <= '0;
      res_cnt   <= '0;
      wb        <= '0;
      xb        <= '0;
      last_a    <= '0;
      idx       <= '0;
      drain_cnt <= '0;
      inst_w    <= 2'b00;
      err       <= 1'b0;
    end else begin
      inst_w <= {state == st_exec, state == st_load};
      if (reading) last_a <= rd_addr;
      if (counting) res_cnt <= res_next;
      case (state)
        st_idle: begin
          if (start) begin
            nv        <= num_vec;
            wb        <= w_base;
            xb        <= x_base;
            err       <= 1'b0;
            res_cnt   <= '0;
            drain_cnt <= '0;
            idx       <= '0;
            state     <= st_load;
          end
        end
        st_load: begin
          if (idx == last_load) begin
            idx   <= '0;
            state <= (nv != '0) ? st_exec : st_drain;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        st_exec: begin
          if (idx == idx_bw'(nv - 1'b1)) begin
            idx   <= '0;
            state <= st_drain;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        st_drain: begin
          drain_cnt <= drain_cnt + 1'b1;
          // Completion wins over timeout when the final result lands on the last cycle.
          if (res_next == nv) begin
            state <= st_done;
          end else if (drain_cnt == last_drain) begin
            err   <= 1'b1;
            state <= st_done;
          end
        end
        st_done: state <= st_idle;
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: a per-run reference model queues expected
// SRAM reads, instructions, FIFO writes and done events; a monitor pops them.
module tb_mac_array_ctrl;

  localparam int col       = 8;
  localparam int len_bw    = 8;
  localparam int addr_bw   = 11;
  localparam int drain_max = 64;
  localparam int amask     = (1 << addr_bw) - 1;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic               clk;
  logic               reset;
  logic               start;
  logic [len_bw-1:0]  num_vec;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] x_base;
  logic [1:0]         inst_w;
  logic               xmem_cen;
  logic [addr_bw-1:0] xmem_a;
  logic [col-1:0]     array_valid;
  logic               ofifo_wr;
  logic               busy;
  logic               done;
  logic               err;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 0;
  bit  prev_rst = 0;
  int  exp_last = 0;
  int  run_v0 = 0;
  int  run_done_at = 0;
  int  run_err = 0;
  int  prev_err = 0;
  bit  vmap [0:511];
  bit  smap [0:511];
  ev_t q_rd[$];
  ev_t q_inst[$];
  ev_t q_wr[$];
  ev_t q_done[$];

  mac_array_ctrl #(
    .col(col), .len_bw(len_bw), .addr_bw(addr_bw), .drain_max(drain_max)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
    .w_base(w_base), .x_base(x_base), .inst_w(inst_w), .xmem_cen(xmem_cen),
    .xmem_a(xmem_a), .array_valid(array_valid), .ofifo_wr(ofifo_wr),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not end in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic reportExtra(input string name, input int act);
    checks++;
    errors++;
    $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected no event", name, cyc, act);
  endtask

  // Reference model: derives every expected event of one run from the rules.
  task automatic computeRun(input int nv, input int wb, input int xb, input int abort);
    int cnt;
    int dstart;
    int c;
    for (int k = 0; k < col; k++) begin
      c = 1 + k;
      if (abort < 0 || c <= abort) q_rd.push_back('{run_v0 + c, (wb + k) & amask});
      if (abort < 0 || c + 1 <= abort) q_inst.push_back('{run_v0 + c + 1, 1});
    end
    for (int j = 0; j < nv; j++) begin
      c = 1 + col + j;
      if (abort < 0 || c <= abort) q_rd.push_back('{run_v0 + c, (xb + j) & amask});
      if (abort < 0 || c + 1 <= abort) q_inst.push_back('{run_v0 + c + 1, 2});
    end
    cnt = 0;
    dstart = 1 + col + nv;
    run_err = 0;
    run_done_at = abort;
    for (int t = 1 + col; t < 512; t++) begin
      if (abort >= 0 && t >= abort) break;
      if (vmap[t] && cnt < nv) begin
        cnt++;
        q_wr.push_back('{run_v0 + t, 1});
      end
      if (t >= dstart && (cnt == nv || t - dstart + 1 == drain_max)) begin
        run_done_at = t + 1;
        run_err = (cnt < nv) ? 1 : 0;
        q_done.push_back('{run_v0 + t + 1, run_err});
        break;
      end
    end
  endtask

  task automatic applyStimulus(input int nv, input int wb, input int xb, input int abort,
                               input bit start_in_done);
    int last;
    @(posedge clk);
    #1;
    prev_err = run_err;
    run_v0 = cyc;
    computeRun(nv, wb, xb, abort);
    if (start_in_done && abort < 0) smap[run_done_at] = 1'b1;
    last = (abort >= 0) ? abort + 3 : run_done_at + 2;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      start = (c == 0) || smap[c];
      if (c == 0) begin
        num_vec = len_bw'(nv);
        w_base  = addr_bw'(wb);
        x_base  = addr_bw'(xb);
      end else begin
        num_vec = len_bw'($urandom);
        w_base  = addr_bw'($urandom);
        x_base  = addr_bw'($urandom);
      end
      array_valid = {vmap[c], (col - 1)'($urandom)};
      reset = (abort >= 0 && c == abort);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    array_valid = '0;
    reset = 1'b0;
    checkOutput("leftover_reads", q_rd.size(), 0);
    checkOutput("leftover_inst", q_inst.size(), 0);
    checkOutput("leftover_writes", q_wr.size(), 0);
    checkOutput("leftover_done", q_done.size(), 0);
    q_rd.delete();
    q_inst.delete();
    q_wr.delete();
    q_done.delete();
    for (int i = 0; i < 512; i++) begin
      vmap[i] = 1'b0;
      smap[i] = 1'b0;
    end
  endtask

  task automatic fillValids(input int pct, input int from, input int upto);
    for (int c = from; c <= upto && c < 512; c++)
      vmap[c] = ($urandom_range(0, 99) < pct);
  endtask

  // Monitor: compares every DUT event against the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    int  c;
    int  e_err;
    if (prev_rst) exp_last = 0;
    prev_rst = reset;
    if (mon_en) begin
      if (!xmem_cen) begin
        if (q_rd.size() == 0) reportExtra("read_extra", int'(xmem_a));
        else begin
          e = q_rd.pop_front();
          checkOutput("read_cycle", cyc, e.cyc);
          checkOutput("read_addr", int'(xmem_a), e.val);
          exp_last = e.val;
        end
      end else begin
        checkOutput("addr_hold", int'(xmem_a), exp_last);
      end
      if (inst_w != 2'b00) begin
        if (q_inst.size() == 0) reportExtra("inst_extra", int'(inst_w));
        else begin
          e = q_inst.pop_front();
          checkOutput("inst_cycle", cyc, e.cyc);
          checkOutput("inst_value", int'(inst_w), e.val);
        end
      end
      if (ofifo_wr) begin
        if (q_wr.size() == 0) reportExtra("ofifo_wr_extra", 1);
        else begin
          e = q_wr.pop_front();
          checkOutput("ofifo_wr_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (q_done.size() == 0) reportExtra("done_extra", 1);
        else begin
          e = q_done.pop_front();
          checkOutput("done_cycle", cyc, e.cyc);
          checkOutput("done_err", int'(err), e.val);
        end
      end
      c = cyc - run_v0;
      if (c <= 0) e_err = prev_err;
      else if (c < run_done_at) e_err = 0;
      else e_err = run_err;
      checkOutput("busy", int'(busy), (c >= 1 && c <= run_done_at) ? 1 : 0);
      checkOutput("err", int'(err), e_err);
    end
  end

  initial begin
    int nv;
    int pct;
    reset = 1'b1;
    start = 1'b1;
    num_vec = 8'd5;
    w_base = '0;
    x_base = '0;
    array_valid = '1;
    for (int i = 0; i < 512; i++) begin
      vmap[i] = 1'b0;
      smap[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_inst_w", int'(inst_w), 0);
    checkOutput("rst_xmem_cen", int'(xmem_cen), 1);
    checkOutput("rst_xmem_a", int'(xmem_a), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_ofifo_wr", int'(ofifo_wr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    array_valid = '0;
    mon_en = 1'b1;

    $display("[TB] basic run");
    vmap[13] = 1; vmap[14] = 1; vmap[16] = 1; vmap[17] = 1;
    applyStimulus(4, 'h010, 'h100, -1, 0);

    $display("[TB] zero vectors");
    applyStimulus(0, 'h020, 'h300, -1, 0);

    $display("[TB] drain timeout");
    vmap[12] = 1; vmap[14] = 1;
    applyStimulus(3, 'h040, 'h200, -1, 0);

    $display("[TB] early and excess valids");
    vmap[3] = 1;
    for (int c = 10; c <= 14; c++) vmap[c] = 1;
    applyStimulus(3, 'h050, 'h250, -1, 0);

    $display("[TB] start while busy");
    smap[10] = 1; smap[12] = 1;
    fillValids(60, 9, 40);
    applyStimulus(6, 'h060, 'h260, -1, 1);

    $display("[TB] reset in execute");
    vmap[10] = 1; vmap[11] = 1;
    applyStimulus(6, 'h070, 'h270, 11, 0);

    $display("[TB] address wrap");
    for (int c = 13; c <= 16; c++) vmap[c] = 1;
    applyStimulus(4, 'h7FC, 'h7FE, -1, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 12; r++) begin
      nv = $urandom_range(0, 24);
      case ($urandom_range(0, 2))
        0: pct = 100;
        1: pct = 40;
        default: pct = 4;
      endcase
      fillValids(pct, 1, 1 + col + nv + 80);
      if ($urandom_range(0, 1) == 1) smap[1 + $urandom_range(0, col + nv)] = 1;
      applyStimulus(nv, $urandom_range(0, amask), $urandom_range(0, amask), -1,
                    $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
